// File: rtl/ring_pkg.sv
// Shared defaults and FSM encoding for the ring-router output-port scheduler.
package ring_pkg;
   localparam int NREQ_DEF  = 3;
   localparam int DEPTH_DEF = 4;
   localparam int CW_DEF    = $clog2(DEPTH_DEF + 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;
endpackage

// File: rtl/ring_credit_counter.sv
// Downstream credit counter: starts full, decrements per sent flit, increments per returned slot.
module ring_credit_counter #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dec,
   input  logic          inc,
   output logic [CW-1:0] credits,
   output logic          nonzero,
   output logic          credit_err
);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= FULL;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // A return with no outstanding flit is a downstream protocol error; saturate and flag it.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (inc && !dec) begin
         if (cnt_q == FULL) err_d = 1'b1;
         else               cnt_d = cnt_q + CW'(1);
      end else if (dec && !inc && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   assign credits    = cnt_q;
   assign nonzero    = (cnt_q != '0);
   assign credit_err = err_q;
endmodule

// File: rtl/ring_port_scheduler.sv
// Wormhole output-port scheduler: round-robin packet arbitration with a per-packet lock
// and credit-gated flit transfer.
module ring_port_scheduler
   import ring_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] tail,
   input  logic            credit_ret,
   output logic [NREQ-1:0] gnt,
   output logic            flit_xfer,
   output logic [CW-1:0]   credits,
   output logic            busy,
   output logic            credit_err
);
   localparam int              OW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [OW-1:0]   RR_INIT = OW'(NREQ - 1);

   state_e          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [OW-1:0]   rr_q, rr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            nonzero;

   // Scan ptr+1, ptr+2, ... mod NREQ; descending loop lets the nearest requester win.
   function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] ptr);
      logic [OW-1:0] win;
      int            idx;
      win = ptr;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(ptr) + i) % NREQ;
         if (r[idx[OW-1:0]]) win = idx[OW-1:0];
      end
      return win;
   endfunction

   ring_credit_counter #(.DEPTH(DEPTH), .CW(CW)) u_credits (
      .clk       (clk),
      .rst       (rst),
      .dec       (flit_xfer),
      .inc       (credit_ret),
      .credits   (credits),
      .nonzero   (nonzero),
      .credit_err(credit_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= RR_INIT;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (|req) begin
               owner_d        = rr_pick(req, rr_q);
               gnt_d[owner_d] = 1'b1;
               state_d        = LOCKED;
            end
         end
         LOCKED: begin
            // Lock is held through requester stalls; only a transferred tail releases it.
            if (flit_xfer && tail[owner_q]) begin
               state_d = IDLE;
               gnt_d   = '0;
               rr_d    = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      flit_xfer = 1'b0;
      if (state_q == LOCKED) flit_xfer = req[owner_q] & nonzero;
   end

   assign gnt  = gnt_q;
   assign busy = (state_q == LOCKED);
endmodule

// File: tb/tb_ring_port_scheduler.sv
// Scoreboard bench for ring_port_scheduler: directed scenarios plus randomized traffic vs. a packet-level model.
module tb_ring_port_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] req = '0;
   logic [2:0] tail = '0;
   logic       credit_ret = 1'b0;
   logic [2:0] gnt;
   logic       flit_xfer;
   logic [2:0] credits;
   logic       busy;
   logic       credit_err;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [2:0] gnt;
      logic       busy;
      logic [2:0] cr;
      logic       err;
      logic       xf;
   } exp_t;

   exp_t q[$];

   // Model: owner -1 means no packet lock; last is the requester that finished most recently.
   int m_owner, m_last, m_cred;
   bit m_err;
   bit m_valid = 1'b0;

   ring_port_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .tail      (tail),
      .credit_ret(credit_ret),
      .gnt       (gnt),
      .flit_xfer (flit_xfer),
      .credits   (credits),
      .busy      (busy),
      .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit m_xfer(input logic [2:0] rq);
      return (m_owner >= 0) && (rq[m_owner] === 1'b1) && (m_cred > 0);
   endfunction

   task automatic m_step(input logic r, input logic [2:0] rq, input logic [2:0] tl, input logic cr);
      bit x;
      if (r) begin
         m_owner = -1; m_last = 2; m_cred = 4; m_err = 1'b0; m_valid = 1'b1;
      end else begin
         x = m_xfer(rq);
         if (x && !cr) m_cred--;
         else if (cr && !x) begin
            if (m_cred == 4) m_err = 1'b1;
            else m_cred++;
         end
         if (m_owner < 0) begin
            for (int k = 1; k <= 3; k++) begin
               if (rq[(m_last + k) % 3]) begin
                  m_owner = (m_last + k) % 3;
                  break;
               end
            end
         end else if (x && tl[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
         end
      end
   endtask

   task automatic drive(input logic r, input logic [2:0] rq, input logic [2:0] tl, input logic cr);
      exp_t e;
      rst = r; req = rq; tail = tl; credit_ret = cr;
      if (m_valid) begin
         e.gnt  = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
         e.busy = (m_owner >= 0);
         e.cr   = 3'(m_cred);
         e.err  = m_err;
         e.xf   = m_xfer(rq);
         q.push_back(e);
      end
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      m_step(rst, req, tail, credit_ret);
      #1;
   endtask

   task automatic cyc(input logic r, input logic [2:0] rq, input logic [2:0] tl, input logic cr);
      drive(r, rq, tl, cr);
      step();
   endtask

   task automatic do_reset();
      cyc(1'b1, 3'b000, 3'b000, 1'b0);
      cyc(1'b1, 3'b000, 3'b000, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("sb_gnt", 8'(gnt), 8'(e.gnt));
         chk("sb_busy", 8'(busy), 8'(e.busy));
         chk("sb_credits", 8'(credits), 8'(e.cr));
         chk("sb_credit_err", 8'(credit_err), 8'(e.err));
         chk("sb_flit_xfer", 8'(flit_xfer), 8'(e.xf));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] rr_exp [4];
      logic [2:0] rq, tl;
      logic       cr, rr;
      rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
      @(posedge clk); #1;

      // Reset then idle
      do_reset();
      drive(1'b0, 3'b000, 3'b000, 1'b0);
      chk("rst_gnt", 8'(gnt), 8'h0);
      chk("rst_busy", 8'(busy), 8'h0);
      chk("rst_credits", 8'(credits), 8'd4);
      chk("rst_err", 8'(credit_err), 8'h0);
      chk("rst_xfer", 8'(flit_xfer), 8'h0);
      step();

      // Single 3-flit packet from requester 1
      cyc(1'b0, 3'b010, 3'b000, 1'b0);
      drive(1'b0, 3'b010, 3'b000, 1'b0);
      chk("pkt_gnt_c1", 8'(gnt), 8'h2);
      chk("pkt_xfer_c1", 8'(flit_xfer), 8'h1);
      step();
      cyc(1'b0, 3'b010, 3'b000, 1'b0);
      cyc(1'b0, 3'b010, 3'b010, 1'b0);
      drive(1'b0, 3'b000, 3'b000, 1'b0);
      chk("pkt_gnt_c4", 8'(gnt), 8'h0);
      chk("pkt_busy_c4", 8'(busy), 8'h0);
      chk("pkt_credits_c4", 8'(credits), 8'd1);
      step();
      for (int i = 0; i < 3; i++) cyc(1'b0, 3'b000, 3'b000, 1'b1);

      // Round-robin with single-flit packets, credits returned on every transfer
      do_reset();
      for (int c = 0; c < 8; c++) begin
         cr = m_xfer(3'b111);
         drive(1'b0, 3'b111, 3'b111, cr);
         if (c % 2 == 1) chk("rr_gnt", 8'(gnt), 8'(rr_exp[c / 2]));
         else            chk("rr_bubble", 8'(gnt), 8'h0);
         step();
      end
      drive(1'b0, 3'b000, 3'b000, 1'b0);
      chk("rr_credits", 8'(credits), 8'd4);
      chk("rr_err", 8'(credit_err), 8'h0);
      step();

      // Credit stall: 6-flit packet from requester 0 with no returns
      do_reset();
      for (int c = 0; c < 5; c++) cyc(1'b0, 3'b001, 3'b000, 1'b0);
      drive(1'b0, 3'b001, 3'b000, 1'b1);
      chk("stall_credits", 8'(credits), 8'd0);
      chk("stall_xfer", 8'(flit_xfer), 8'h0);
      chk("stall_gnt", 8'(gnt), 8'h1);
      step();
      drive(1'b0, 3'b001, 3'b000, 1'b0);
      chk("stall_resume_xfer", 8'(flit_xfer), 8'h1);
      step();
      drive(1'b0, 3'b001, 3'b001, 1'b0);
      chk("stall_again_xfer", 8'(flit_xfer), 8'h0);
      step();

      // Simultaneous transfer/return, then overflow
      do_reset();
      cyc(1'b0, 3'b001, 3'b000, 1'b0);
      cyc(1'b0, 3'b001, 3'b000, 1'b0);
      cyc(1'b0, 3'b001, 3'b000, 1'b1);
      drive(1'b0, 3'b000, 3'b000, 1'b1);
      chk("simul_credits", 8'(credits), 8'd3);
      step();
      cyc(1'b0, 3'b000, 3'b000, 1'b1);
      drive(1'b0, 3'b000, 3'b000, 1'b0);
      chk("ovf_credits", 8'(credits), 8'd4);
      chk("ovf_err", 8'(credit_err), 8'h1);
      step();
      for (int i = 0; i < 3; i++) cyc(1'b0, 3'b000, 3'b000, 1'b0);
      drive(1'b0, 3'b000, 3'b000, 1'b0);
      chk("ovf_err_sticky", 8'(credit_err), 8'h1);
      step();

      // Reset mid-packet
      do_reset();
      cyc(1'b0, 3'b100, 3'b000, 1'b0);
      cyc(1'b0, 3'b100, 3'b000, 1'b0);
      cyc(1'b0, 3'b100, 3'b000, 1'b0);
      drive(1'b1, 3'b100, 3'b000, 1'b0);
      chk("midrst_gnt_before", 8'(gnt), 8'h4);
      step();
      drive(1'b0, 3'b111, 3'b000, 1'b0);
      chk("midrst_gnt", 8'(gnt), 8'h0);
      chk("midrst_credits", 8'(credits), 8'd4);
      chk("midrst_busy", 8'(busy), 8'h0);
      step();
      drive(1'b0, 3'b111, 3'b000, 1'b0);
      chk("midrst_first_gnt", 8'(gnt), 8'h1);
      step();

      // Randomized traffic checked by the scoreboard
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         rr = ($urandom_range(0, 99) == 0);
         rq = 3'($urandom);
         rq = rq | 3'($urandom);
         tl = 3'($urandom) & 3'($urandom);
         cr = ($urandom_range(0, 99) < 35);
         cyc(rr, rq, tl, cr);
      end
      drive(1'b0, 3'b000, 3'b000, 1'b0);
      step();
      @(negedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
